// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
//
// Shared definitions for the button event classifier:
//   - evt_code_t : 2-bit event code carried on the event bus
//   - EVT_*      : event code values (SHORT, DOUBLE, LONG, REPEAT)
//   - state_t    : classifier FSM state vector
//   - ST_*       : classifier FSM state encoding
//   - max3()     : constant helper used to size the shared tick counter
//
// No ports; imported by the interface, the buffer and the top module.
// ---------------------------------------------------------------------------
package btn_evt_pkg;

  // Event code presented to the UI/LCD control logic.
  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_SHORT  = 2'd0;
  localparam evt_code_t EVT_DOUBLE = 2'd1;
  localparam evt_code_t EVT_LONG   = 2'd2;
  localparam evt_code_t EVT_REPEAT = 2'd3;

  // Classifier FSM state vector and encoding. Plain constants (not an enum)
  // so the encoding stays visible to tools and legacy code that probe it.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;  // waiting for a first press
  localparam state_t ST_PRESS1 = 3'd1;  // first press held, timing for LONG
  localparam state_t ST_WAIT2  = 3'd2;  // released, timing the double-click gap
  localparam state_t ST_PRESS2 = 3'd3;  // second press held, DOUBLE on release
  localparam state_t ST_HELD   = 3'd4;  // LONG already reported, wait for release

  // Largest of three integers; used at elaboration time only.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : btn_evt_pkg

// File: rtl/btn_evt_if.sv
// ---------------------------------------------------------------------------
// btn_evt_if
//
// Event bus between the button event classifier and its consumer.
//   evt_valid  classifier -> consumer  an event is available
//   evt_code   classifier -> consumer  event code (see btn_evt_pkg::EVT_*)
//   evt_drop   classifier -> consumer  one-cycle pulse: an event was lost
//   evt_ready  consumer -> classifier  consumer takes the event this cycle
//
// Modports:
//   master : the classifier side (drives valid/code/drop, samples ready)
//   slave  : the consumer side (samples valid/code/drop, drives ready)
// ---------------------------------------------------------------------------
interface btn_evt_if;
  import btn_evt_pkg::*;

  logic      evt_valid;
  evt_code_t evt_code;
  logic      evt_drop;
  logic      evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_drop,
    output evt_ready
  );

endinterface : btn_evt_if

// File: rtl/btn_evt_buffer.sv
// ---------------------------------------------------------------------------
// btn_evt_buffer
//
// One-entry valid/ready holding register for classified button events.
// A new event is accepted when the buffer is empty or when the held event
// is being transferred in the same cycle; otherwise the new event is
// discarded, the held event is left untouched and drop pulses for one cycle.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   an event is offered this cycle
//   load_code  in   code of the offered event
//   ready      in   consumer accepts the held event (valid & ready)
//   valid      out  an event is held
//   code       out  held event code, stable while valid is high
//   drop       out  one-cycle pulse, the cycle after an event was discarded
// ---------------------------------------------------------------------------
module btn_evt_buffer
  import btn_evt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  evt_code_t load_code,
  input  logic      ready,
  output logic      valid,
  output evt_code_t code,
  output logic      drop
);

  // The held event leaves this cycle, so its slot is free for a new one.
  logic accept;
  assign accept = valid & ready;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      code  <= EVT_SHORT;
      drop  <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (load) begin
        if (!valid || accept) begin
          valid <= 1'b1;
          code  <= load_code;
        end else begin
          // Full and not draining: keep the older event, flag the loss.
          drop <= 1'b1;
        end
      end else if (accept) begin
        // Code is left as-is; it is only meaningful while valid is high.
        valid <= 1'b0;
      end
    end
  end

endmodule : btn_evt_buffer

// File: rtl/button_event_classifier.sv
// ---------------------------------------------------------------------------
// button_event_classifier
//
// Turns debounced button activity into discrete user events:
//   SHORT  : press released before LONG_MS ticks, no re-press within
//            DOUBLE_GAP_MS ticks
//   DOUBLE : second press started within DOUBLE_GAP_MS ticks of a release,
//            reported when that second press is released
//   LONG   : press held for LONG_MS ticks
//   REPEAT : every REPEAT_MS ticks while still held after LONG
//            (only when BTN_AUTO_REPEAT_EN is defined)
// Events are handed to the consumer through a one-entry valid/ready buffer.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  defined   -> HELD emits REPEAT every REPEAT_MS ticks
//                       undefined -> HELD only waits for release; code 3 is
//                                    never produced and REPEAT_MS is unused
//
// Parameters (in ticks of tick_1khz, each >= 2):
//   LONG_MS        hold time for LONG
//   DOUBLE_GAP_MS  maximum release-to-press gap for DOUBLE
//   REPEAT_MS      auto-repeat period after LONG
//
// Ports:
//   clk        in   system clock, single domain
//   rst        in   synchronous active-high reset
//   tick_1khz  in   one-cycle 1 kHz enable
//   btn_state  in   debounced level (1 = pressed)
//   btn_rise   in   one-cycle press pulse
//   btn_fall   in   one-cycle release pulse
//   evt        if   event bus, master side (evt_valid/evt_code/evt_drop out,
//                   evt_ready in)
// ---------------------------------------------------------------------------
module button_event_classifier
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS       = 800,
  parameter int DOUBLE_GAP_MS = 250,
  parameter int REPEAT_MS     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic       btn_state,
  input  logic       btn_rise,
  input  logic       btn_fall,
  btn_evt_if.master  evt
);

  // One counter serves every timed state, so it is sized for the longest
  // interval any of them measures.
  localparam int CNT_MAX = max3(LONG_MS, DOUBLE_GAP_MS, REPEAT_MS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_MS - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             emit;
  evt_code_t        emit_code;

  // The FSM state already tells which edge is meaningful (a rise only while
  // released, a fall only while pressed), so the level is not needed to
  // qualify the pulses; it is kept on the port for the debouncer contract.
  logic unused_btn_state;
  assign unused_btn_state = btn_state;

  // -------------------------------------------------------------------------
  // Next-state and event decode.
  // An edge pulse always wins over a coincident tick: the edge transition is
  // taken and that tick's threshold compare is skipped.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    cnt_clr   = 1'b0;
    emit      = 1'b0;
    emit_code = EVT_SHORT;

    case (state)
      ST_IDLE: begin
        if (btn_rise) state_nxt = ST_PRESS1;
      end

      ST_PRESS1: begin
        if (btn_fall) begin
          state_nxt = ST_WAIT2;
        end else if (tick_1khz && cnt == LONG_LAST) begin
          // This tick completes LONG_MS ticks of hold.
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_nxt = ST_HELD;
        end
      end

      ST_WAIT2: begin
        if (btn_rise) begin
          state_nxt = ST_PRESS2;
        end else if (tick_1khz && cnt == GAP_LAST) begin
          // Gap expired without a second press: it was a single click.
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_nxt = ST_IDLE;
        end
      end

      ST_PRESS2: begin
        // A second press is never promoted to LONG; only its release matters.
        if (btn_fall) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_nxt = ST_IDLE;
        end
      end

      ST_HELD: begin
        if (btn_fall) begin
          state_nxt = ST_IDLE;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (tick_1khz && cnt == REP_LAST) begin
          // Stay in HELD; restart the period for the next REPEAT.
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          cnt_clr   = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and shared tick counter.
  // The counter restarts on every state change so each state measures time
  // from its own entry; it saturates instead of wrapping so a long stay in a
  // state that ignores it can never alias back onto a threshold.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || cnt_clr) begin
        cnt <= '0;
      end else if (tick_1khz && cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output holding register.
  // -------------------------------------------------------------------------
  btn_evt_buffer u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (emit),
    .load_code (emit_code),
    .ready     (evt.evt_ready),
    .valid     (evt.evt_valid),
    .code      (evt.evt_code),
    .drop      (evt.evt_drop)
  );

endmodule : button_event_classifier

// File: tb/tb_button_event_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_event_classifier
//
// Self-checking bench for button_event_classifier. A reference model that
// reasons in terms of "number of presses, button held or not, ticks elapsed
// since the last edge" predicts every emitted event and the buffer occupancy;
// predicted events go into a scoreboard queue that a separate monitor drains
// whenever the DUT transfers an event. Directed sequences are followed by
// randomized press/gap/ready patterns.
// ---------------------------------------------------------------------------
module tb_button_event_classifier;
  import btn_evt_pkg::*;

  localparam int LONG_MS       = 800;
  localparam int DOUBLE_GAP_MS = 250;
  localparam int REPEAT_MS     = 100;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn_state;
  logic btn_rise;
  logic btn_fall;

  btn_evt_if evt ();

  always #5 clk = ~clk;

  button_event_classifier #(
    .LONG_MS       (LONG_MS),
    .DOUBLE_GAP_MS (DOUBLE_GAP_MS),
    .REPEAT_MS     (REPEAT_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1khz (tick),
    .btn_state (btn_state),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .evt       (evt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model (evaluated at each rising edge on the inputs that are
  // stable for that edge).
  // ---------------------------------------------------------------------
  evt_code_t exp_q[$];     // scoreboard: event expected in the buffer
  evt_code_t seen[$];      // codes actually transferred by the DUT
  bit        m_full = 0;   // model buffer occupied
  bit        m_drop = 0;   // model expects drop pulse this cycle
  int        m_presses = 0;
  bit        m_down = 0;
  bit        m_long = 0;
  int        m_t = 0;
  int        n_push = 0;
  int        n_xfer = 0;
  int        n_drop = 0;
  bit        m_accept;
  bit        m_emit;
  evt_code_t m_code;

  task automatic m_clear();
    m_presses = 0;
    m_down    = 0;
    m_long    = 0;
    m_t       = 0;
  endtask

  always @(posedge clk) begin
    m_accept = m_full && (evt.evt_ready === 1'b1);
    m_emit   = 1'b0;
    m_code   = EVT_SHORT;
    m_drop   = 1'b0;
    if (rst) begin
      m_clear();
      m_full = 1'b0;
      exp_q.delete();
    end else begin
      if (btn_rise && !m_down) begin
        // First press, or re-press inside the double-click window.
        m_presses = m_presses + 1;
        m_down    = 1'b1;
        m_t       = 0;
      end else if (btn_fall && m_down) begin
        if (m_long) begin
          m_clear();
        end else if (m_presses == 1) begin
          m_down = 1'b0;
          m_t    = 0;
        end else begin
          m_emit = 1'b1;
          m_code = EVT_DOUBLE;
          m_clear();
        end
      end else if (tick) begin
        if (m_down && m_presses == 1) begin
          m_t = m_t + 1;
          if (!m_long && m_t == LONG_MS) begin
            m_emit = 1'b1;
            m_code = EVT_LONG;
            m_long = 1'b1;
            m_t    = 0;
          end else if (m_long && REPEAT_ON && m_t == REPEAT_MS) begin
            m_emit = 1'b1;
            m_code = EVT_REPEAT;
            m_t    = 0;
          end
        end else if (!m_down && m_presses == 1) begin
          m_t = m_t + 1;
          if (m_t == DOUBLE_GAP_MS) begin
            m_emit = 1'b1;
            m_code = EVT_SHORT;
            m_clear();
          end
        end
      end

      if (m_emit) begin
        if (!m_full || m_accept) begin
          exp_q.push_back(m_code);
          n_push++;
          m_full = 1'b1;
        end else begin
          m_drop = 1'b1;
        end
      end else if (m_accept) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor: compares DUT outputs with the model away from the clock edge.
  // ---------------------------------------------------------------------
  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("evt_valid", 32'(evt.evt_valid), 32'(m_full));
      check("evt_drop", 32'(evt.evt_drop), 32'(m_drop));
      if (evt.evt_drop === 1'b1) n_drop++;
      if (evt.evt_valid === 1'b1 && exp_q.size() > 0)
        check("evt_code", 32'(evt.evt_code), 32'(exp_q[0]));
      if (evt.evt_valid === 1'b1 && evt.evt_ready === 1'b1) begin
        n_xfer++;
        seen.push_back(evt.evt_code);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------
  // Consumer ready driver: 0 = low, 1 = high, 2 = random.
  // ---------------------------------------------------------------------
  int ready_mode = 1;

  initial begin
    evt.evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       evt.evt_ready = 1'b0;
        1:       evt.evt_ready = 1'b1;
        default: evt.evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 ns after a rising edge.
  // ---------------------------------------------------------------------
  task automatic cyc(input bit r, input bit f, input bit t);
    @(posedge clk);
    #2;
    btn_rise = r;
    btn_fall = f;
    tick     = t;
    if (r) btn_state = 1'b1;
    if (f) btn_state = 1'b0;
  endtask

  // n ticks, one every other clock.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int n_code(input evt_code_t c);
    int n = 0;
    foreach (seen[i]) if (seen[i] == c) n++;
    return n;
  endfunction

  task automatic expect_counts(input string name, input int s, input int d,
                               input int l, input int r);
    check({name, "_short"},  32'(n_code(EVT_SHORT)),  32'(s));
    check({name, "_double"}, 32'(n_code(EVT_DOUBLE)), 32'(d));
    check({name, "_long"},   32'(n_code(EVT_LONG)),   32'(l));
    check({name, "_repeat"}, 32'(n_code(EVT_REPEAT)), 32'(r));
    seen.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst      = 1'b1;
    btn_rise = 1'b0;
    btn_fall = 1'b0;
    tick     = 1'b1;  // a tick inside the reset cycle must have no effect
    @(posedge clk);
    #2;
    rst  = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(evt.evt_valid), 32'd0);
    check("rst_code",  32'(evt.evt_code),  32'(EVT_SHORT));
    check("rst_drop",  32'(evt.evt_drop),  32'd0);
  endtask

  // Watchdog: the bench never waits on DUT events, but never hang regardless.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p;
  int g;
  int p2;
  int drop0;

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    btn_state = 1'b0;
    btn_rise  = 1'b0;
    btn_fall  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("init_valid", 32'(evt.evt_valid), 32'd0);
    check("init_code",  32'(evt.evt_code),  32'(EVT_SHORT));
    check("init_drop",  32'(evt.evt_drop),  32'd0);
    mon_en = 1'b1;

    // Short press.
    cyc(1, 0, 0); ticks(100); cyc(0, 1, 0); ticks(DOUBLE_GAP_MS); settle();
    expect_counts("short", 1, 0, 0, 0);

    // Double click.
    cyc(1, 0, 0); ticks(100); cyc(0, 1, 0); ticks(100);
    cyc(1, 0, 0); ticks(50); cyc(0, 1, 0); settle();
    expect_counts("double", 0, 1, 0, 0);

    // Long press held 1000 ticks in total.
    cyc(1, 0, 0); ticks(1000); cyc(0, 1, 0); settle();
    expect_counts("long", 0, 0, 1, REPEAT_ON ? 2 : 0);

    // Backpressure: two shorts while the consumer stalls.
    ready_mode = 0;
    drop0 = n_drop;
    cyc(1, 0, 0); ticks(20); cyc(0, 1, 0); ticks(DOUBLE_GAP_MS + 2);
    cyc(1, 0, 0); ticks(20); cyc(0, 1, 0); ticks(DOUBLE_GAP_MS + 2);
    check("bp_held_count", 32'(seen.size()), 32'd0);
    check("bp_drop_count", 32'(n_drop - drop0), 32'd1);
    ready_mode = 1;
    settle();
    expect_counts("bp", 1, 0, 0, 0);

    // Release coincident with the LONG_MS-th tick: no LONG, becomes a SHORT.
    cyc(1, 0, 0); ticks(LONG_MS - 1); cyc(0, 1, 1);
    ticks(DOUBLE_GAP_MS + 2); settle();
    expect_counts("coinc_fall", 1, 0, 0, 0);

    // Re-press coincident with the DOUBLE_GAP_MS-th tick: DOUBLE, no SHORT.
    cyc(1, 0, 0); ticks(10); cyc(0, 1, 0); ticks(DOUBLE_GAP_MS - 1);
    cyc(1, 0, 1); ticks(5); cyc(0, 1, 0); settle();
    expect_counts("coinc_rise", 0, 1, 0, 0);

    // Reset 400 ticks into a press; the later release yields nothing.
    cyc(1, 0, 0); ticks(400);
    do_reset();
    ticks(10); cyc(0, 1, 0); ticks(DOUBLE_GAP_MS + 10); settle();
    expect_counts("rst_mid", 0, 0, 0, 0);

    // Randomized presses, gaps, coincident ticks and consumer stalls.
    ready_mode = 2;
    for (int s = 0; s < 12; s++) begin
      p = $urandom_range(1, 900);
      g = $urandom_range(1, 300);
      cyc(1, 0, 0);
      ticks(p);
      cyc(0, 1, $urandom_range(0, 1) != 0);
      ticks(g);
      if ($urandom_range(0, 1) != 0) begin
        p2 = $urandom_range(1, 200);
        cyc(1, 0, $urandom_range(0, 1) != 0);
        ticks(p2);
        cyc(0, 1, $urandom_range(0, 1) != 0);
      end
      ticks(DOUBLE_GAP_MS + 5);
    end
    ready_mode = 1;
    settle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("transfer_count", 32'(n_xfer), 32'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_event_classifier
